// File: rtl/spi_pixel_receiver_pkg.sv
// spi_rx_pkg: shared types and constants for the SPI pixel receiver.
package spi_rx_pkg;
  typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_PUSH} spi_rx_state_t;
  localparam int SYNC_STAGES = 2;
  localparam int SPI_BITS = 8;
endpackage

// File: rtl/spi_pixel_receiver_if.sv
// spi_pixel_receiver_if: valid/ready byte stream between receiver and pixel consumer.
interface spi_pixel_receiver_if #(parameter int RGB_SIZE = 8);
  logic [RGB_SIZE-1:0] data;
  logic valid;
  logic ready;
  modport master (output data, valid, input ready);
  modport slave (input data, valid, output ready);
endinterface

// File: rtl/spi_pixel_receiver_byte_fifo.sv
// byte_fifo: show-ahead FIFO; a push into a full FIFO lands only if a pop frees a slot that cycle.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign empty = cnt_q == '0;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign count = cnt_q;
  assign head_data = mem_q[rd_q];
  always_comb begin
    do_pop = pop & ~empty;
    do_push = push & (~full | do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = push_data;
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/spi_pixel_receiver.sv
// spi_pixel_receiver: SPI mode-0 slave feeding a byte FIFO and valid/ready pixel stream.
// Define SPI_ECHO_EN to echo the previous completed byte on spi_miso.
module spi_pixel_receiver
  import spi_rx_pkg::*;
#(
  parameter int IMAGE_SIZE = 256,
  parameter int RGB_SIZE = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        spi_clk,
  input  logic                        spi_mosi,
  input  logic                        spi_cs_n,
  output logic                        spi_miso,
  output logic                        mcu_rx_rdy,
  spi_pixel_receiver_if.master        pix,
  output logic [IMAGE_ADDR_WIDTH-1:0] pixel_count,
  output logic                        frame_done,
  output logic                        err_overflow,
  output logic                        err_short,
  input  logic                        err_clr
);
  localparam int CW = $clog2(SPI_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
  logic sclk_prev_q, cs_prev_q, sclk_s, mosi_s, cs_s, sclk_rise, cs_fall;
  spi_rx_state_t state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [SPI_BITS-1:0] shift_q, shift_d;
  logic [IMAGE_ADDR_WIDTH-1:0] pixel_cnt_q, pixel_cnt_d;
  logic frame_done_q, frame_done_d, err_ovf_q, err_ovf_d, err_short_q, err_short_d, rdy_q, rdy_d;
  logic push, pop, short_err, empty, full, last;
  logic [AW:0] fifo_cnt;
  logic [RGB_SIZE-1:0] head;
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign cs_fall = ~cs_s & cs_prev_q;
  assign pix.data = head;
  assign pix.valid = ~empty;
  assign pop = pix.valid & pix.ready;
  assign last = pixel_cnt_q == IMAGE_ADDR_WIDTH'(IMAGE_SIZE - 1);
  assign pixel_count = pixel_cnt_q;
  assign frame_done = frame_done_q;
  assign err_overflow = err_ovf_q;
  assign err_short = err_short_q;
  assign mcu_rx_rdy = rdy_q;
  always_comb begin
    state_d = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d = shift_q;
    push = 1'b0;
    short_err = 1'b0;
    case (state_q)
      RX_IDLE: begin
        bit_cnt_d = '0;
        state_d = cs_fall ? RX_SHIFT : RX_IDLE;
      end
      RX_SHIFT:
        if (cs_s) begin
          short_err = |bit_cnt_q;
          bit_cnt_d = '0;
          state_d = RX_IDLE;
        end else if (sclk_rise) begin
          shift_d = {shift_q[SPI_BITS-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d = (bit_cnt_q == CW'(SPI_BITS - 1)) ? RX_PUSH : RX_SHIFT;
        end
      RX_PUSH: begin
        push = 1'b1;
        bit_cnt_d = '0;
        state_d = cs_s ? RX_IDLE : RX_SHIFT;
      end
      default: state_d = RX_IDLE;
    endcase
    err_ovf_d = (push & full & ~pop) | (err_ovf_q & ~err_clr);
    err_short_d = short_err | (err_short_q & ~err_clr);
    rdy_d = fifo_cnt <= (AW+1)'(FIFO_DEPTH - 2);
    pixel_cnt_d = pop ? (last ? '0 : pixel_cnt_q + 1'b1) : pixel_cnt_q;
    frame_done_d = pop & last;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q <= 1'b1;
      state_q <= RX_IDLE;
      bit_cnt_q <= '0;
      shift_q <= '0;
      pixel_cnt_q <= '0;
      frame_done_q <= 1'b0;
      err_ovf_q <= 1'b0;
      err_short_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_sync_q <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      sclk_prev_q <= sclk_s;
      cs_prev_q <= cs_s;
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q <= shift_d;
      pixel_cnt_q <= pixel_cnt_d;
      frame_done_q <= frame_done_d;
      err_ovf_q <= err_ovf_d;
      err_short_q <= err_short_d;
      rdy_q <= rdy_d;
    end
`ifdef SPI_ECHO_EN
  // The MSB leaves on CS fall so it is valid before the first SCLK rise.
  logic [SPI_BITS-1:0] echo_q, echo_d;
  logic miso_q, miso_d, sclk_fall;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign spi_miso = miso_q;
  always_comb begin
    echo_d = (state_q == RX_PUSH) ? shift_q : echo_q;
    miso_d = cs_s ? 1'b0 : (cs_fall | sclk_fall) ? echo_q[CW'(SPI_BITS - 1) - bit_cnt_q] : miso_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      echo_q <= '0;
      miso_q <= 1'b0;
    end else begin
      echo_q <= echo_d;
      miso_q <= miso_d;
    end
`else
  assign spi_miso = 1'b0;
`endif
  byte_fifo #(.WIDTH(RGB_SIZE), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .push_data(RGB_SIZE'(shift_q)),
    .pop(pop),
    .head_data(head),
    .empty(empty),
    .full(full),
    .count(fifo_cnt)
  );
endmodule

// File: tb/tb_spi_pixel_receiver.sv
// tb_spi_pixel_receiver: directed bench for spi_pixel_receiver; SPI bits run at clk/8.
module tb_spi_pixel_receiver;
  logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, mosi = 1'b0, cs_n = 1'b1, err_clr = 1'b0;
  logic miso, rdy, fd, ovf, shrt;
  logic [7:0] pcnt, b, e, last_pop;
  int passed = 0, fails = 0, total = 0, pops = 0, fd_cnt = 0, fd_at = 0;
  spi_pixel_receiver_if #(.RGB_SIZE(8)) pix ();
  spi_pixel_receiver dut (
    .clk(clk), .rst_n(rst_n), .spi_clk(sclk), .spi_mosi(mosi), .spi_cs_n(cs_n),
    .spi_miso(miso), .mcu_rx_rdy(rdy), .pix(pix.master), .pixel_count(pcnt),
    .frame_done(fd), .err_overflow(ovf), .err_short(shrt), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (rst_n && pix.valid && pix.ready) begin pops++; last_pop = pix.data; end
  always @(negedge clk) if (fd) begin fd_cnt++; fd_at = pops; end
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(int n); repeat (n) @(negedge clk); endtask
  task automatic bit_out(logic v); mosi = v; cyc(4); sclk = 1'b1; cyc(4); sclk = 1'b0; endtask
  task automatic byte_out(logic [7:0] v); for (int i = 7; i >= 0; i--) bit_out(v[i]); endtask
  task automatic cs_low; cs_n = 1'b0; cyc(4); endtask
  task automatic cs_high; cyc(4); cs_n = 1'b1; cyc(4); endtask
  initial begin
    pix.ready = 1'b0;
    cyc(2);
    chk("reset_valid", pix.valid, 0);
    chk("reset_data", pix.data, 0);
    chk("reset_outs", {pcnt, fd, ovf, shrt, rdy, miso}, 0);
    rst_n = 1'b1;
    cyc(2);
    chk("rdy_after_reset", rdy, 1);
    // single byte A5 with exact latency
    b = 8'hA5;
    cs_low();
    for (int i = 7; i >= 1; i--) bit_out(b[i]);
    mosi = b[0]; cyc(4); sclk = 1'b1; cyc(3);
    chk("latency_not_yet", pix.valid, 0);
    cyc(1);
    chk("latency_valid", pix.valid, 1);
    chk("latency_data", pix.data, 8'hA5);
    cyc(3); sclk = 1'b0;
    cs_high();
    chk("single_no_short", shrt, 0);
    chk("single_hold", pix.data, 8'hA5);
    chk("miso_cs_high", miso, 0);
    pix.ready = 1'b1; cyc(1); pix.ready = 1'b0;
    chk("single_popped", pix.valid, 0);
    chk("count_1", pcnt, 1);
    // second byte 3C; echo build returns A5 on MISO
    b = 8'h3C; e = 8'hA5;
    cs_low();
    for (int i = 7; i >= 0; i--) begin
      mosi = b[i]; cyc(4);
`ifdef SPI_ECHO_EN
      chk("echo_bit", miso, e[i]);
`else
      chk("miso_tied", miso, 0);
`endif
      sclk = 1'b1; cyc(4); sclk = 1'b0;
    end
    cs_high();
    chk("byte_3c", pix.data, 8'h3C);
    pix.ready = 1'b1; cyc(1); pix.ready = 1'b0;
    chk("count_2", pcnt, 2);
    // short byte
    b = 8'hFF;
    cs_low();
    for (int i = 0; i < 5; i++) bit_out(1'b1);
    cs_high();
    chk("short_flag", shrt, 1);
    chk("short_no_push", pix.valid, 0);
    err_clr = 1'b1; cyc(1); err_clr = 1'b0;
    chk("short_cleared", shrt, 0);
    // backpressure and overflow
    cs_low();
    byte_out(8'h01); cyc(2); chk("rdy_occ1", rdy, 1);
    byte_out(8'h02); cyc(2); chk("rdy_occ2", rdy, 1);
    byte_out(8'h03); cyc(2); chk("rdy_occ3", rdy, 0);
    byte_out(8'h04); cyc(2); chk("ovf_before", ovf, 0);
    byte_out(8'h05); cyc(2); chk("ovf_set", ovf, 1);
    cs_high();
    for (int k = 1; k <= 4; k++) begin
      chk("drain_data", pix.data, k);
      pix.ready = 1'b1; cyc(1);
    end
    pix.ready = 1'b0;
    chk("drain_empty", pix.valid, 0);
    chk("count_6", pcnt, 6);
    cyc(2);
    chk("rdy_drained", rdy, 1);
    err_clr = 1'b1; cyc(1); err_clr = 1'b0;
    chk("ovf_cleared", ovf, 0);
    // full FIFO: push and pop together
    cs_low();
    for (int k = 8'h10; k <= 8'h13; k++) byte_out(8'(k));
    cyc(2);
    chk("full_rdy", rdy, 0);
    b = 8'h14;
    for (int i = 7; i >= 1; i--) bit_out(b[i]);
    mosi = b[0]; cyc(4); sclk = 1'b1; cyc(3);
    pix.ready = 1'b1; cyc(1); pix.ready = 1'b0;
    cyc(3); sclk = 1'b0;
    cs_high();
    chk("full_pushpop_no_ovf", ovf, 0);
    chk("full_pushpop_rdy", rdy, 0);
    for (int k = 8'h11; k <= 8'h14; k++) begin
      chk("full_drain_data", pix.data, k);
      pix.ready = 1'b1; cyc(1);
    end
    pix.ready = 1'b0;
    chk("full_drain_empty", pix.valid, 0);
    chk("count_11", pcnt, 11);
    // reset mid-byte with a buffered byte
    cs_low();
    byte_out(8'h77);
    bit_out(1'b1); bit_out(1'b0); bit_out(1'b1);
    rst_n = 1'b0; #1;
    chk("midrst_valid", pix.valid, 0);
    chk("midrst_data", pix.data, 0);
    chk("midrst_outs", {pcnt, fd, ovf, shrt, rdy, miso}, 0);
    cs_n = 1'b1; cyc(4); rst_n = 1'b1; cyc(4);
    chk("postrst_empty", pix.valid, 0);
    // full frame
    pops = 0; fd_cnt = 0;
    pix.ready = 1'b1;
    cs_low();
    for (int n = 0; n < 256; n++) byte_out(8'(n));
    cyc(4);
    chk("frame_pops", pops, 256);
    chk("frame_last_data", last_pop, 8'hFF);
    chk("frame_done_once", fd_cnt, 1);
    chk("frame_done_at", fd_at, 256);
    chk("frame_wrap", pcnt, 0);
    byte_out(8'hEE);
    cyc(4);
    chk("after_frame_count", pcnt, 1);
    chk("after_frame_data", last_pop, 8'hEE);
    chk("after_frame_fd", fd_cnt, 1);
    cs_high();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
